// File: rtl/bidir_piso_serializer.sv
// Parallel-in, serial-out shift register with per-word MSB/LSB-first direction.
// Optional build macro PISO_PARITY_EN appends an even-parity bit after each word.
module bidir_piso_serializer #(
    parameter int DATA_WID = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [DATA_WID-1:0] load_data,
    input  logic                Dir,
    output logic                ser_out,
    output logic                ser_valid,
    output logic                done
);

`ifdef PISO_PARITY_EN
    localparam int LAST = DATA_WID;
`else
    localparam int LAST = DATA_WID - 1;
`endif
    localparam int CNT_W = $clog2(LAST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_reg, state_next;
    logic [DATA_WID-1:0] shreg_reg, shreg_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                dir_reg, dir_next;
    logic [DATA_WID-1:0] shl, shr;
    logic                last_bit;
    logic                accept;

    assign last_bit = (state_reg == SHIFT) && (cnt_reg == LAST_CNT);
    assign accept   = load_valid && load_ready;

    // Zero-filled one-place shifts toward the MSB and toward the LSB.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WID; gi++) begin : g_shift
            if (gi == 0) begin : g_lo
                assign shl[gi] = 1'b0;
            end else begin : g_lo_n
                assign shl[gi] = shreg_reg[gi-1];
            end
            if (gi == DATA_WID - 1) begin : g_hi
                assign shr[gi] = 1'b0;
            end else begin : g_hi_n
                assign shr[gi] = shreg_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_bit && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        if (accept) begin
            shreg_next = load_data;
            dir_next   = Dir;
            cnt_next   = '0;
        end else if (state_reg == SHIFT) begin
            shreg_next = dir_reg ? shl : shr;
            cnt_next   = last_bit ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_reg <= '0;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
        end else begin
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
        end
    end

`ifdef PISO_PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else if (accept) begin
            parity_reg <= ^load_data;
        end
    end
`endif

    always_comb begin
        load_ready = (state_reg == IDLE) || last_bit;
        ser_valid  = (state_reg == SHIFT);
        done       = last_bit;
        ser_out    = 1'b0;
        if (state_reg == SHIFT) begin
            ser_out = dir_reg ? shreg_reg[DATA_WID-1] : shreg_reg[0];
`ifdef PISO_PARITY_EN
            // Final slot of the word carries the stored parity instead of data.
            if (last_bit) ser_out = parity_reg;
`endif
        end
    end

endmodule
